// File: rtl/cache_nwsa_pkg.sv
// cache_nwsa_pkg: shared definitions for the N-way set-associative cache.
//   - state_t      : controller states
//   - idx_w/tag_w/beat_w/age_w : derived field widths from the cache parameters
//   - addr_idx/addr_tag        : split a CPU word address into set index and tag
package cache_nwsa_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WRITEBACK = 3'd2,
        FILL      = 3'd3,
        RESPOND   = 3'd4
    } state_t;

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets);
        return addr_w - $clog2(sets);
    endfunction

    // Requires DATA_W/MEM_W >= 2 so the beat field has at least one bit.
    function automatic int beat_w(input int data_w, input int mem_w);
        return $clog2(data_w / mem_w);
    endfunction

    // Also used as the way-number width; a direct-mapped cache keeps 1 bit.
    function automatic int age_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic logic [31:0] addr_idx(input logic [31:0] addr, input int iw);
        return addr & ((32'd1 << iw) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int iw);
        return addr >> iw;
    endfunction

endpackage

// File: rtl/cache_lru_set.sv
// cache_lru_set: age update and victim choice for one set.
//   ages     in  : current age of every way in the set
//   valid    in  : valid bit of every way in the set
//   way      in  : way being accessed (hit way or newly filled way)
//   ages_upd out : ages after the access
//   victim   out : lowest invalid way, else the oldest way (lowest index on ties)
// With WAYS=1 all of this collapses to constants.
module cache_lru_set
    import cache_nwsa_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int AGE_W = 1,
    parameter int WAY_W = 1
) (
    input  logic [WAYS-1:0][AGE_W-1:0] ages,
    input  logic [WAYS-1:0]            valid,
    input  logic [WAY_W-1:0]           way,
    output logic [WAYS-1:0][AGE_W-1:0] ages_upd,
    output logic [WAY_W-1:0]           victim
);

    generate
        if (WAYS == 1) begin : g_dm
            logic unused_ok;
            assign unused_ok = ^{ages, valid, way};
            assign ages_upd  = '0;
            assign victim    = '0;
        end else begin : g_lru
            localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(WAYS - 1);

            logic [AGE_W-1:0] old_age;
            logic [AGE_W-1:0] best_age;
            logic             found;

            // An invalid way being filled counts as the oldest, so every
            // live way ages by one and the orders stay distinct from reset.
            assign old_age = valid[way] ? ages[way] : AGE_MAX;

            always_comb begin
                ages_upd = ages;
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == way)
                        ages_upd[w] = '0;
                    else if (ages[w] < old_age && ages[w] != AGE_MAX)
                        ages_upd[w] = ages[w] + AGE_W'(1);
                end
            end

            always_comb begin
                victim   = '0;
                found    = 1'b0;
                best_age = ages[0];
                for (int w = 0; w < WAYS; w++) begin
                    if (!found && !valid[w]) begin
                        victim = WAY_W'(w);
                        found  = 1'b1;
                    end
                end
                if (!found) begin
                    for (int w = 1; w < WAYS; w++) begin
                        if (ages[w] > best_age) begin
                            victim   = WAY_W'(w);
                            best_age = ages[w];
                        end
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/cache_nwsa.sv
// cache_nwsa: N-way set-associative, write-back, write-allocate cache with a
// one-word block moved over a narrow memory bus in DATA_W/MEM_W beats.
//   clock, reset_n        : rising-edge clock, async active-low reset
//   addr_cpu, rd_cpu, wr_cpu, data_cpu_in : CPU request (rd wins over wr)
//   data_cpu_out, stall_cpu               : CPU response / hold
//   addr_mem, rd_mem, wr_mem, data_mem_out: registered memory beat request
//   data_mem_in, ready_mem                : memory fill data / beat accept
// Optional build macro CACHE_STATS_EN adds saturating 16-bit counters
//   hit_count, miss_count, wb_count.
module cache_nwsa
    import cache_nwsa_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int MEM_W  = 8,
    parameter int WAYS   = 2,
    parameter int SETS   = 8
) (
    input  logic                                    clock,
    input  logic                                    reset_n,
    input  logic [ADDR_W-1:0]                       addr_cpu,
    input  logic                                    rd_cpu,
    input  logic                                    wr_cpu,
    input  logic [DATA_W-1:0]                       data_cpu_in,
    output logic [DATA_W-1:0]                       data_cpu_out,
    output logic                                    stall_cpu,
    output logic [ADDR_W+beat_w(DATA_W,MEM_W)-1:0]  addr_mem,
    output logic                                    rd_mem,
    output logic                                    wr_mem,
    output logic [MEM_W-1:0]                        data_mem_out,
    input  logic [MEM_W-1:0]                        data_mem_in,
`ifdef CACHE_STATS_EN
    output logic [15:0]                             hit_count,
    output logic [15:0]                             miss_count,
    output logic [15:0]                             wb_count,
`endif
    input  logic                                    ready_mem
);

    localparam int BEATS  = DATA_W / MEM_W;
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, SETS);
    localparam int BEAT_W = beat_w(DATA_W, MEM_W);
    localparam int AGE_W  = age_w(WAYS);
    localparam int WAY_W  = age_w(WAYS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    // Tag/data contents are never reset; only the per-set state is.
    logic [TAG_W-1:0]             tag_arr  [WAYS][SETS];
    logic [DATA_W-1:0]            data_arr [WAYS][SETS];
    logic [WAYS-1:0]              valid    [SETS];
    logic [WAYS-1:0]              dirty    [SETS];
    logic [WAYS-1:0][AGE_W-1:0]   ages     [SETS];

    state_t              state, state_n;
    logic [ADDR_W-1:0]   laddr;
    logic                lwr;
    logic [DATA_W-1:0]   ldata;
    logic [WAY_W-1:0]    lway;
    logic [BEAT_W-1:0]   beat, beat_nx;
    logic [DATA_W-1:0]   fill_word;
    logic [DATA_W-1:0]   wb_word;
    logic [ADDR_W-1:0]   wb_addr;
    logic                done;

    logic [IDX_W-1:0]    lidx;
    logic [TAG_W-1:0]    ltag;
    logic [WAYS-1:0]     hit_vec;
    logic [WAY_W-1:0]    hit_way;
    logic                hit;
    logic [WAY_W-1:0]    victim;
    logic [WAY_W-1:0]    acc_way;
    logic [WAYS-1:0][AGE_W-1:0] ages_upd;
    logic                need_wb;
    logic                start;
    logic                beat_last;

    assign lidx      = IDX_W'(addr_idx(32'(laddr), IDX_W));
    assign ltag      = TAG_W'(addr_tag(32'(laddr), IDX_W));
    assign hit       = |hit_vec;
    assign need_wb   = valid[lidx][victim] & dirty[lidx][victim];
    assign start     = (rd_cpu | wr_cpu) & ~done;
    assign beat_last = (beat == LAST_BEAT);
    assign beat_nx   = beat + BEAT_W'(1);
    assign acc_way   = (state == RESPOND) ? lway : hit_way;

    // Gated by reset_n so every output reads 0 while reset is held.
    assign stall_cpu = reset_n & (rd_cpu | wr_cpu) & ~done;

    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (valid[lidx][w] && tag_arr[w][lidx] == ltag) hit_vec[w] = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--)
            if (hit_vec[w]) hit_way = WAY_W'(w);
    end

    cache_lru_set #(.WAYS(WAYS), .AGE_W(AGE_W), .WAY_W(WAY_W)) u_lru (
        .ages     (ages[lidx]),
        .valid    (valid[lidx]),
        .way      (acc_way),
        .ages_upd (ages_upd),
        .victim   (victim)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (start) state_n = LOOKUP;
            LOOKUP:    state_n = hit ? IDLE : (need_wb ? WRITEBACK : FILL);
            WRITEBACK: if (ready_mem && beat_last) state_n = FILL;
            FILL:      if (ready_mem && beat_last) state_n = RESPOND;
            RESPOND:   state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done         <= 1'b0;
            data_cpu_out <= '0;
            rd_mem       <= 1'b0;
            wr_mem       <= 1'b0;
            addr_mem     <= '0;
            data_mem_out <= '0;
            laddr        <= '0;
            lwr          <= 1'b0;
            ldata        <= '0;
            lway         <= '0;
            beat         <= '0;
            fill_word    <= '0;
            wb_word      <= '0;
            wb_addr      <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                ages[s]  <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        laddr <= addr_cpu;
                        lwr   <= ~rd_cpu;
                        ldata <= data_cpu_in;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        done       <= 1'b1;
                        ages[lidx] <= ages_upd;
                        if (lwr) dirty[lidx][hit_way] <= 1'b1;
                        else     data_cpu_out <= data_arr[hit_way][lidx];
                    end else begin
                        lway <= victim;
                        beat <= '0;
                        if (need_wb) begin
                            wr_mem       <= 1'b1;
                            wb_addr      <= {tag_arr[victim][lidx], lidx};
                            wb_word      <= data_arr[victim][lidx];
                            addr_mem     <= {tag_arr[victim][lidx], lidx, {BEAT_W{1'b0}}};
                            data_mem_out <= data_arr[victim][lidx][MEM_W-1:0];
                        end else begin
                            rd_mem   <= 1'b1;
                            addr_mem <= {laddr, {BEAT_W{1'b0}}};
                        end
                    end
                end
                WRITEBACK: begin
                    if (ready_mem) begin
                        if (beat_last) begin
                            wr_mem       <= 1'b0;
                            rd_mem       <= 1'b1;
                            beat         <= '0;
                            addr_mem     <= {laddr, {BEAT_W{1'b0}}};
                            data_mem_out <= '0;
                        end else begin
                            beat         <= beat_nx;
                            addr_mem     <= {wb_addr, beat_nx};
                            data_mem_out <= wb_word[beat_nx*MEM_W +: MEM_W];
                        end
                    end
                end
                FILL: begin
                    if (ready_mem) begin
                        fill_word[beat*MEM_W +: MEM_W] <= data_mem_in;
                        if (beat_last) begin
                            rd_mem   <= 1'b0;
                            addr_mem <= '0;
                        end else begin
                            beat     <= beat_nx;
                            addr_mem <= {laddr, beat_nx};
                        end
                    end
                end
                RESPOND: begin
                    done               <= 1'b1;
                    valid[lidx][lway]  <= 1'b1;
                    dirty[lidx][lway]  <= lwr;
                    ages[lidx]         <= ages_upd;
                    if (!lwr) data_cpu_out <= fill_word;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (state == LOOKUP && hit && lwr)
            data_arr[hit_way][lidx] <= ldata;
        if (state == RESPOND) begin
            tag_arr[lway][lidx]  <= ltag;
            data_arr[lway][lidx] <= lwr ? ldata : fill_word;
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else if (state == LOOKUP) begin
            if (hit) begin
                if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            end else begin
                if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
                if (need_wb && wb_count != 16'hFFFF) wb_count <= wb_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_nwsa.sv
// tb_cache_nwsa: directed bench for cache_nwsa (WAYS=2, SETS=8, 4 beats).
// A byte-wide memory model answers fill beats and absorbs writebacks; every
// memory beat is logged so the sequence of addresses and data can be checked.
module tb_cache_nwsa;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [8:0]  addr_cpu = '0;
    logic        rd_cpu = 1'b0;
    logic        wr_cpu = 1'b0;
    logic [31:0] data_cpu_in = '0;
    logic [31:0] data_cpu_out;
    logic        stall_cpu;
    logic [10:0] addr_mem;
    logic        rd_mem, wr_mem;
    logic [7:0]  data_mem_out;
    logic [7:0]  data_mem_in;
    logic        ready_mem = 1'b1;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_count, miss_count, wb_count;
`endif

    always #5 clock = ~clock;

    cache_nwsa dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .addr_cpu     (addr_cpu),
        .rd_cpu       (rd_cpu),
        .wr_cpu       (wr_cpu),
        .data_cpu_in  (data_cpu_in),
        .data_cpu_out (data_cpu_out),
        .stall_cpu    (stall_cpu),
        .addr_mem     (addr_mem),
        .rd_mem       (rd_mem),
        .wr_mem       (wr_mem),
        .data_mem_out (data_mem_out),
        .data_mem_in  (data_mem_in),
`ifdef CACHE_STATS_EN
        .hit_count    (hit_count),
        .miss_count   (miss_count),
        .wb_count     (wb_count),
`endif
        .ready_mem    (ready_mem)
    );

    logic [7:0]  mem [2048];
    logic [10:0] rd_log [$];
    logic [10:0] wr_log [$];
    logic [7:0]  wd_log [$];
    logic        both_hi = 1'b0;

    assign data_mem_in = mem[addr_mem];

    always @(posedge clock) begin
        if (rd_mem && wr_mem) both_hi = 1'b1;
        if (rd_mem && ready_mem) rd_log.push_back(addr_mem);
        if (wr_mem && ready_mem) begin
            wr_log.push_back(addr_mem);
            wd_log.push_back(data_mem_out);
            mem[addr_mem] = data_mem_out;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m0(input int a);
        return 8'(a * 7 + 3);
    endfunction

    function automatic logic [31:0] word_init(input int wa);
        return {m0(wa*4+3), m0(wa*4+2), m0(wa*4+1), m0(wa*4)};
    endfunction

    task automatic clear_logs();
        rd_log.delete();
        wr_log.delete();
        wd_log.delete();
    endtask

    // One CPU request; returns edges until stall drops and the read data.
    task automatic cpu_op(input logic is_wr, input logic [8:0] a, input logic [31:0] d,
                          output int edges, output logic [31:0] rdata);
        @(negedge clock);
        addr_cpu = a; rd_cpu = ~is_wr; wr_cpu = is_wr; data_cpu_in = d;
        edges = 0;
        do begin
            @(negedge clock);
            edges++;
        end while (stall_cpu && edges < 200);
        rdata = data_cpu_out;
        rd_cpu = 1'b0; wr_cpu = 1'b0;
    endtask

    initial begin
        int e;
        logic [31:0] r;

        for (int i = 0; i < 2048; i++) mem[i] = m0(i);
        mem[11'h1A4] = 8'hAA; mem[11'h1A5] = 8'hBB;
        mem[11'h1A6] = 8'hCC; mem[11'h1A7] = 8'hDD;

        // Reset state
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rst_stall", stall_cpu, 0);
        chk("rst_rd_wr", {rd_mem, wr_mem}, 0);
        chk("rst_addr_mem", addr_mem, 0);
        chk("rst_data_out", data_cpu_out, 0);
        chk("rst_data_mem_out", data_mem_out, 0);

        // 1: cold read of 0x069
        clear_logs();
        cpu_op(1'b0, 9'h069, 32'h0, e, r);
        chk("t1_edges", e, 7);
        chk("t1_data", r, 32'hDDCCBBAA);
        chk("t1_nrd", rd_log.size(), 4);
        chk("t1_nwr", wr_log.size(), 0);
        if (rd_log.size() == 4)
            for (int i = 0; i < 4; i++) chk("t1_rd_addr", rd_log[i], 11'h1A4 + 11'(i));

        // 2: re-read hits
        clear_logs();
        cpu_op(1'b0, 9'h069, 32'h0, e, r);
        chk("t2_edges", e, 2);
        chk("t2_data", r, 32'hDDCCBBAA);
        chk("t2_nrd", rd_log.size(), 0);

        // 3: write hit, fill way 1, then evict dirty way 0
        clear_logs();
        cpu_op(1'b1, 9'h069, 32'h99999999, e, r);
        chk("t3_wr_edges", e, 2);
        chk("t3_wr_nmem", rd_log.size() + wr_log.size(), 0);
        cpu_op(1'b0, 9'h0E9, 32'h0, e, r);
        chk("t3_e9_edges", e, 7);
        chk("t3_e9_data", r, word_init(9'h0E9));
        clear_logs();
        cpu_op(1'b0, 9'h169, 32'h0, e, r);
        chk("t3_169_edges", e, 11);
        chk("t3_169_data", r, word_init(9'h169));
        chk("t3_nwr", wr_log.size(), 4);
        chk("t3_nrd", rd_log.size(), 4);
        if (wr_log.size() == 4)
            for (int i = 0; i < 4; i++) begin
                chk("t3_wb_addr", wr_log[i], 11'h1A4 + 11'(i));
                chk("t3_wb_data", wd_log[i], 8'h99);
            end
        if (rd_log.size() == 4)
            for (int i = 0; i < 4; i++) chk("t3_fill_addr", rd_log[i], 11'h5A4 + 11'(i));
`ifdef CACHE_STATS_EN
        chk("t6_hits", hit_count, 2);
        chk("t6_miss", miss_count, 3);
        chk("t6_wb", wb_count, 1);
`endif

        // LRU: touch 0x0E9 so 0x169 becomes oldest; 0x069 refills from the
        // written-back memory and must not displace 0x0E9.
        cpu_op(1'b0, 9'h0E9, 32'h0, e, r);
        chk("lru_e9_hit", e, 2);
        clear_logs();
        cpu_op(1'b0, 9'h069, 32'h0, e, r);
        chk("lru_069_edges", e, 7);
        chk("lru_069_data", r, 32'h99999999);
        chk("lru_069_nwr", wr_log.size(), 0);
        cpu_op(1'b0, 9'h0E9, 32'h0, e, r);
        chk("lru_e9_keep", e, 2);

        // 4: ready_mem low for 3 cycles after the first fill beat
        clear_logs();
        @(negedge clock);
        addr_cpu = 9'h0AA; rd_cpu = 1'b1;
        e = 0;
        do begin
            @(negedge clock);
            e++;
            if (e == 3) begin
                chk("t4_addr_b1", addr_mem, {9'h0AA, 2'd1});
                ready_mem = 1'b0;
            end else if (e >= 4 && e <= 6) begin
                chk("t4_addr_hold", addr_mem, {9'h0AA, 2'd1});
                chk("t4_rd_hold", rd_mem, 1);
                if (e == 6) ready_mem = 1'b1;
            end
        end while (stall_cpu && e < 200);
        r = data_cpu_out;
        rd_cpu = 1'b0;
        ready_mem = 1'b1;
        chk("t4_edges", e, 10);
        chk("t4_data", r, word_init(9'h0AA));
        chk("t4_nrd", rd_log.size(), 4);

        // 5: reset in the middle of a fill
        @(negedge clock);
        addr_cpu = 9'h0F3; rd_cpu = 1'b1;
        repeat (3) @(negedge clock);
        chk("t5_in_fill", rd_mem, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_stall", stall_cpu, 0);
        chk("t5_rd_mem", rd_mem, 0);
        chk("t5_addr_mem", addr_mem, 0);
        chk("t5_data_out", data_cpu_out, 0);
`ifdef CACHE_STATS_EN
        chk("t5_stats", {hit_count, miss_count, wb_count}, 0);
`endif
        @(negedge clock);
        rd_cpu = 1'b0;
        reset_n = 1'b1;
        clear_logs();
        cpu_op(1'b0, 9'h0F3, 32'h0, e, r);
        chk("t5_f3_edges", e, 7);
        chk("t5_f3_data", r, word_init(9'h0F3));
        chk("t5_f3_nrd", rd_log.size(), 4);
        cpu_op(1'b0, 9'h069, 32'h0, e, r);
        chk("t5_069_miss", e, 7);
        chk("t5_069_data", r, 32'h99999999);

        chk("mem_exclusive", both_hi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_nwsa.md
Name: cache_nwsa

Overview:
Parametrised N-way set-associative, write-back, write-allocate cache between the CPU port and a narrow main-memory port; successor of the fixed 2-way cache_2wsa. Block size is one CPU word, moved to or from memory as DATA_W/MEM_W narrow beats. Replacement is true LRU per set via age counters. Invalid ways are filled before any eviction.

Parameters:
ADDR_W, 9, CPU word-address width.
DATA_W, 32, CPU word width.
MEM_W, 8, memory data width; DATA_W/MEM_W = BEATS, must be a power of 2.
WAYS, 2, associativity; power of 2, 1..8.
SETS, 8, sets per way; power of 2; index width IDX_W = log2(SETS), tag width = ADDR_W-IDX_W.

Ports:
clock  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
addr_cpu  in  ADDR_W  CPU word address.
rd_cpu  in  1  read request.
wr_cpu  in  1  write request; rd_cpu has priority if both are high.
data_cpu_in  in  DATA_W  write data.
data_cpu_out  out  DATA_W  read data, valid while stall_cpu=0 after a read.
stall_cpu  out  1  request pending or not yet complete.
addr_mem  out  ADDR_W+log2(BEATS)  beat address {word addr, beat}.
rd_mem  out  1  fill beat request.
wr_mem  out  1  writeback beat request.
data_mem_out  out  MEM_W  writeback beat data.
data_mem_in  in  MEM_W  fill beat data.
ready_mem  in  1  beat completes at this edge when high with rd_mem or wr_mem.

Behaviour:
- Reset (async): FSM goes to IDLE. All outputs are 0. Valid, dirty and LRU ages clear. Tag and data arrays are not reset. Reset mid-transfer abandons the transfer with no partial state kept.
- stall_cpu = (rd_cpu|wr_cpu) & ~done. done is a registered one-cycle pulse.
- A request high on a cycle after done is a new request.
- FSM states: IDLE, LOOKUP, WRITEBACK, FILL, RESPOND.
  - IDLE: on rd_cpu|wr_cpu, latch address, op and data; go to LOOKUP. Later changes to the inputs are ignored.
  - LOOKUP: compare the tags of all valid ways in the indexed set.
    - Hit: read loads data_cpu_out; write updates the word and sets dirty. Update LRU, pulse done, go to IDLE. Hit latency is 2 edges from request.
    - Miss: victim is the lowest-index invalid way, else the way with the maximum age. Go to WRITEBACK if the victim is valid and dirty, else FILL.
  - WRITEBACK: wr_mem=1, addr_mem={victim tag, index, beat}, data_mem_out = victim word slice [beat*MEM_W +: MEM_W]. Beat advances only on ready_mem. After the last beat go to FILL.
  - FILL: rd_mem=1, addr_mem={latched addr, beat}. Capture data_mem_in into slice beat on each ready_mem, LSB beat first. After the last beat go to RESPOND.
  - RESPOND: install tag and set valid. Dirty = (op==write). A write merges data_cpu_in over the filled word. A read drives data_cpu_out. Update LRU, pulse done, go to IDLE.
- rd_mem and wr_mem are never high together and are registered.
- ready_mem low holds the beat counter and all memory outputs unchanged.
- LRU: the accessed way's age becomes 0. Ways with age below its old age increment. Ages saturate at WAYS-1.
- WAYS=1 degenerates to direct-mapped: LRU logic is removed and the victim is always way 0.

Optional Feature:
CACHE_STATS_EN. When defined, add ports hit_count out 16 and miss_count out 16, plus wb_count out 16 (writebacks).
- Each counter increments once per LOOKUP outcome or per WRITEBACK entry, and saturates at 0xFFFF.
- All counters clear on reset.
When the macro is undefined, these ports and their logic are absent.

Decomposition:
Package cache_nwsa_pkg holds:
- the state enum localparams;
- derived widths IDX_W, TAG_W, BEAT_W, AGE_W;
- the address field extract functions.
Sub-module cache_lru_set: per-set age update and victim selection, parametrised on WAYS. It is instantiated once and indexed by the latched set.

Test Plan:
1. Cold read of 0x069 (WAYS=2, SETS=8; index 1, tag 0x0D). Memory returns AA, BB, CC, DD -> 4 rd_mem beats at addr_mem 0x1A4..0x1A7, no wr_mem, data_cpu_out 0xDDCCBBAA, done after the 4th beat plus 1.
2. Re-read 0x069 -> no rd_mem, stall_cpu low after 2 edges, data 0xDDCCBBAA.
3. Write 0x069 = 0x99999999 (hit, dirty). Read 0x0E9 (fill way 1). Read 0x169 -> 4 wr_mem beats at 0x1A4..0x1A7 each carrying 0x99, then 4 fill beats at 0x5A4..0x5A7.
4. ready_mem low for 3 cycles after beat 1 of a fill -> addr_mem holds at beat 1, completion delayed exactly 3 cycles, data correct.
5. reset_n pulsed low during FILL -> outputs 0 asynchronously. A following read of the same address misses again.
6. With CACHE_STATS_EN, run sequence 1-3 -> hit_count 2, miss_count 3, wb_count 1.
